keypad_scanner: RTL and testbench

Matrix-keypad front end for the vending-machine controller: drives the four active-low row strobes of a 4x4 keypad and samples the four active-low column returns. It debounces the press, then emits a one-cycle key event with a 4-bit key code. It is the driving end of the row/column interface that the vending FSM decodes, and replaces raw `r`/`c` pin stimulus with a clean scanned key stream.

---
 rtl/keypad_scanner_pkg.sv | 34 +++
 rtl/keypad_scanner_sync.sv | 23 ++
 rtl/keypad_scanner.sv | 176 +++++++++++++++++
 tb/tb_keypad_scanner.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_scanner_pkg.sv
// Shared types and constants for the 4x4 matrix keypad scanner.
package keypad_pkg;

  localparam int KP_ROWS = 4;
  localparam int KP_COLS = 4;
  localparam int KEY_W   = 4;

  localparam logic [KP_ROWS-1:0] ROW_IDLE = 4'b1111;

  typedef enum logic [1:0] {
    ST_SCAN       = 2'd0,
    ST_PRESS_DB   = 2'd1,
    ST_PRESSED    = 2'd2,
    ST_RELEASE_DB = 2'd3
  } kp_state_t;

  function automatic logic [KP_ROWS-1:0] row_strobe(input logic [1:0] idx);
    logic [KP_ROWS-1:0] s;
    s = ROW_IDLE;
    s[idx] = 1'b0;
    return s;
  endfunction

  // Column returns are active-low; the lowest-index low column wins.
  function automatic logic [1:0] lowest_low_col(input logic [KP_COLS-1:0] cols);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = KP_COLS - 1; i >= 0; i--) begin
      if (!cols[i]) idx = i[1:0];
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_scanner_sync.sv
// Two-flop synchronizer; resets to all-ones so idle (released) columns read high.
module keypad_sync #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad row scanner with press/release debounce; KEYPAD_AUTOREPEAT_EN adds auto-repeat.
// state      | meaning
// SCAN       | strobe rows in turn, sample columns at end of each dwell
// PRESS_DB   | row frozen, counting stable-low cycles on the latched column
// PRESSED    | key accepted, waiting for the latched column to go high
// RELEASE_DB | counting stable-high cycles before returning to SCAN
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV      = 16,
  parameter int DEBOUNCE_CNT  = 1000,
  parameter int REPEAT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] c,
  output logic [3:0] r,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic       key_held
);

  localparam int DWELL_W = $clog2(SCAN_DIV);
  localparam int DB_W    = $clog2(DEBOUNCE_CNT + 1);

  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SCAN_DIV - 1);
  localparam logic [DB_W-1:0]    DB_DONE    = DB_W'(DEBOUNCE_CNT);

  if (SCAN_DIV < 2 || DEBOUNCE_CNT < 1 || REPEAT_CYCLES < 1) begin : g_param_check
    $error("keypad_scanner: parameter out of range");
  end

  kp_state_t          state, state_nx;
  logic [1:0]         row_idx, row_nx;
  logic [1:0]         col_idx, col_nx;
  logic [DWELL_W-1:0] dwell_cnt, dwell_nx;
  logic [DB_W-1:0]    db_cnt, db_nx, db_inc;
  logic               valid_nx, held_nx;
  logic [KEY_W-1:0]   code_nx;
  logic [KP_COLS-1:0] c_sync;
  logic               col_low, any_low;

  keypad_sync #(.WIDTH(KP_COLS)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (c),
    .q     (c_sync)
  );

  assign col_low = ~c_sync[col_idx];
  assign any_low = ~(&c_sync);
  assign db_inc  = (db_cnt == DB_DONE) ? db_cnt : db_cnt + DB_W'(1);

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int               REP_W    = $clog2(REPEAT_CYCLES + 1);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);

  logic [REP_W-1:0] rep_cnt, rep_nx;

  always_ff @(posedge clk) begin
    if (reset) rep_cnt <= '0;
    else       rep_cnt <= rep_nx;
  end
`endif

  always_comb begin
    state_nx = state;
    row_nx   = row_idx;
    col_nx   = col_idx;
    dwell_nx = dwell_cnt;
    db_nx    = db_cnt;
    valid_nx = 1'b0;
    code_nx  = key_code;
    held_nx  = key_held;
`ifdef KEYPAD_AUTOREPEAT_EN
    rep_nx   = rep_cnt;
`endif

    case (state)
      ST_SCAN: begin
        if (dwell_cnt == DWELL_LAST) begin
          dwell_nx = '0;
          if (any_low) begin
            col_nx   = lowest_low_col(c_sync);
            db_nx    = '0;
            state_nx = ST_PRESS_DB;
          end else begin
            row_nx = row_idx + 2'd1;
          end
        end else begin
          dwell_nx = dwell_cnt + DWELL_W'(1);
        end
      end

      ST_PRESS_DB: begin
        if (!col_low) begin
          db_nx    = '0;
          row_nx   = row_idx + 2'd1;
          state_nx = ST_SCAN;
        end else begin
          db_nx = db_inc;
          if (db_inc == DB_DONE) begin
            valid_nx = 1'b1;
            code_nx  = {row_idx, col_idx};
            held_nx  = 1'b1;
            state_nx = ST_PRESSED;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_nx   = '0;
`endif
          end
        end
      end

      ST_PRESSED: begin
        if (!col_low) begin
          db_nx    = '0;
          state_nx = ST_RELEASE_DB;
        end
`ifdef KEYPAD_AUTOREPEAT_EN
        else if (rep_cnt == REP_LAST) begin
          valid_nx = 1'b1;
          rep_nx   = '0;
        end else begin
          rep_nx = rep_cnt + REP_W'(1);
        end
`endif
      end

      ST_RELEASE_DB: begin
        if (col_low) begin
          db_nx    = '0;
          state_nx = ST_PRESSED;
`ifdef KEYPAD_AUTOREPEAT_EN
          rep_nx   = '0;
`endif
        end else begin
          db_nx = db_inc;
          if (db_inc == DB_DONE) begin
            db_nx    = '0;
            held_nx  = 1'b0;
            row_nx   = row_idx + 2'd1;
            state_nx = ST_SCAN;
          end
        end
      end

      default: state_nx = ST_SCAN;
    endcase
  end

  // r is registered from the next row index so the pins never glitch through two low rows.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_SCAN;
      row_idx   <= 2'd0;
      col_idx   <= 2'd0;
      dwell_cnt <= '0;
      db_cnt    <= '0;
      r         <= row_strobe(2'd0);
      key_valid <= 1'b0;
      key_code  <= '0;
      key_held  <= 1'b0;
    end else begin
      state     <= state_nx;
      row_idx   <= row_nx;
      col_idx   <= col_nx;
      dwell_cnt <= dwell_nx;
      db_cnt    <= db_nx;
      r         <= row_strobe(row_nx);
      key_valid <= valid_nx;
      key_code  <= code_nx;
      key_held  <= held_nx;
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner; a behavioural 4x4 matrix turns pressed keys into column returns.
module tb_keypad_scanner;

  localparam int SCAN_DIV      = 4;
  localparam int DEBOUNCE_CNT  = 8;
  localparam int REPEAT_CYCLES = 40;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  c;
  logic [3:0]  r;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_held;
  logic [15:0] keys = 16'h0000;

  int n = 0;
  int pulses = 0;
  int vectors = 0;
  int miscompares = 0;
  int p0, p1;

  always #5 clk = ~clk;

  // Pressed key (row, col) = keys[row*4+col]; it pulls its column low while its row is strobed.
  always_comb begin
    c = 4'b1111;
    for (int row = 0; row < 4; row++) begin
      if (r[row] == 1'b0) begin
        for (int col = 0; col < 4; col++) begin
          if (keys[row*4+col]) c[col] = 1'b0;
        end
      end
    end
  end

  keypad_scanner #(
    .SCAN_DIV      (SCAN_DIV),
    .DEBOUNCE_CNT  (DEBOUNCE_CNT),
    .REPEAT_CYCLES (REPEAT_CYCLES)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .c         (c),
    .r         (r),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_held  (key_held)
  );

  function automatic logic [3:0] exp_row(input int i);
    logic [3:0] v;
    v = 4'b1111;
    v[i] = 1'b0;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    n++;
    if (key_valid === 1'b1) pulses++;
  endtask

  task automatic run_to(input int target);
    while (n < target) tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    n = 0;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b (cycle %0d)", tag, obs, exp, n);
    end
  endtask

  task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b (cycle %0d)", tag, obs, exp, n);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, n);
    end
  endtask

  initial begin
    // Reset values
    do_reset();
    chk4("rst_r", r, 4'b1110);
    chk1("rst_valid", key_valid, 1'b0);
    chk4("rst_code", key_code, 4'h0);
    chk1("rst_held", key_held, 1'b0);

    // Idle scan: row advances every SCAN_DIV cycles, wrapping 3 -> 0
    p0 = pulses;
    while (n < 40) begin
      chk4("scan_r", r, exp_row((n / 4) % 4));
      chk1("scan_valid", key_valid, 1'b0);
      tick();
    end
    chki("scan_events", pulses - p0, 0);

    // Key (row 2, col 1): row 2 strobed from cycle 8, sampled at 12, event 8 cycles later
    do_reset();
    keys = 16'h0200;
    p0 = pulses;
    run_to(19);
    chk4("press_r_frozen", r, 4'b1011);
    chk1("press_valid_early", key_valid, 1'b0);
    chk4("press_code_early", key_code, 4'h0);
    run_to(20);
    chk1("press_valid", key_valid, 1'b1);
    chk4("press_code", key_code, 4'b1001);
    chk1("press_held", key_held, 1'b1);
    run_to(21);
    chk1("press_valid_1cyc", key_valid, 1'b0);
    run_to(59);
    chki("press_events", pulses - p0, 1);
    chk4("press_r_hold", r, 4'b1011);
    chk1("press_held_hold", key_held, 1'b1);

    // 3-cycle glitch on (row 2, col 1): enters PRESS_DB, aborts, scan resumes at row 3
    keys = 16'h0000;
    do_reset();
    chk4("rst2_code", key_code, 4'h0);
    chk1("rst2_held", key_held, 1'b0);
    p0 = pulses;
    run_to(9);
    keys = 16'h0200;
    run_to(12);
    keys = 16'h0000;
    chk4("glitch_r_frozen", r, 4'b1011);
    run_to(15);
    chk4("glitch_r_row3", r, 4'b0111);
    run_to(18);
    chk4("glitch_r_dwell", r, 4'b0111);
    run_to(19);
    chk4("glitch_r_wrap", r, 4'b1110);
    run_to(30);
    chki("glitch_events", pulses - p0, 0);
    chk1("glitch_held", key_held, 1'b0);

    // Release bounce: 3 cycles up, 5 down, then released for good
    do_reset();
    keys = 16'h0200;
    p0 = pulses;
    run_to(20);
    chk1("bounce_accept", key_valid, 1'b1);
    run_to(25);
    keys = 16'h0000;
    run_to(28);
    keys = 16'h0200;
    run_to(30);
    chk1("bounce_held_mid", key_held, 1'b1);
    run_to(33);
    keys = 16'h0000;
    run_to(43);
    chk1("bounce_held_last", key_held, 1'b1);
    chk4("bounce_r_frozen", r, 4'b1011);
    run_to(44);
    chk1("bounce_held_fall", key_held, 1'b0);
    chk4("bounce_r_next", r, 4'b0111);
    chki("bounce_events", pulses - p0, 1);

    // Two keys in row 0 (cols 0 and 3): lowest column wins
    keys = 16'h0009;
    p0 = pulses;
    run_to(59);
    chk1("multi_valid_early", key_valid, 1'b0);
    chk4("multi_code_prev", key_code, 4'b1001);
    run_to(60);
    chk1("multi_valid", key_valid, 1'b1);
    chk4("multi_code", key_code, 4'b0000);
    chk1("multi_held", key_held, 1'b1);
    chk4("multi_r", r, 4'b1110);
    run_to(61);
    keys = 16'h0000;
    run_to(71);
    chk1("multi_held_last", key_held, 1'b1);
    run_to(72);
    chk1("multi_held_fall", key_held, 1'b0);
    chk4("multi_r_next", r, 4'b1101);

    // Reset during PRESS_DB on (row 2, col 1) discards the pending event
    keys = 16'h0200;
    run_to(80);
    chk4("abort_r_frozen", r, 4'b1011);
    run_to(84);
    chk1("abort_valid_pre", key_valid, 1'b0);
    reset = 1'b1;
    keys = 16'h0000;
    tick();
    reset = 1'b0;
    n = 0;
    chk4("abort_r", r, 4'b1110);
    chk1("abort_held", key_held, 1'b0);
    chk1("abort_valid", key_valid, 1'b0);
    chk4("abort_code", key_code, 4'h0);
    p1 = pulses;
    run_to(20);
    chki("abort_events", pulses - p1, 0);
    chki("multi_events", pulses - p0, 1);

    // Hold (row 3, col 2) for 130 cycles after acceptance
    do_reset();
    keys = 16'h4000;
    p0 = pulses;
    run_to(16);
    chk4("hold_r_frozen", r, 4'b0111);
    run_to(23);
    chk1("hold_valid_early", key_valid, 1'b0);
    run_to(24);
    chk1("hold_valid", key_valid, 1'b1);
    chk4("hold_code", key_code, 4'b1110);
    run_to(63);
    chk1("hold_valid_63", key_valid, 1'b0);
    run_to(64);
`ifdef KEYPAD_AUTOREPEAT_EN
    chk1("hold_repeat_64", key_valid, 1'b1);
`else
    chk1("hold_repeat_64", key_valid, 1'b0);
`endif
    chk4("hold_code_64", key_code, 4'b1110);
    run_to(154);
`ifdef KEYPAD_AUTOREPEAT_EN
    chki("hold_events", pulses - p0, 4);
`else
    chki("hold_events", pulses - p0, 1);
`endif
    chk4("hold_code_end", key_code, 4'b1110);
    chk1("hold_held_end", key_held, 1'b1);
    keys = 16'h0000;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
